// File: rtl/timer_ctrl.sv
// MM:SS entry and BCD countdown controller with a tick-counted alarm phase.
// Optional feature macro: TIMER_PAUSE_EN adds PAUSE and makes i_start in RUN a pause/resume toggle.
module timer_ctrl #(
  parameter int ALARM_TICKS = 5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key_valid,
  input  logic [4:0] i_bcd_data,
  input  logic       i_start,
  input  logic       i_clear,
  input  logic       i_tick,
  output logic [3:0] o_min_t,
  output logic [3:0] o_min_o,
  output logic [3:0] o_sec_t,
  output logic [3:0] o_sec_o,
  output logic [2:0] o_entry_cnt,
  output logic       o_running,
  output logic       o_done
);

  // state | meaning
  // IDLE  | cleared, waiting for the first digit
  // ENTRY | shifting digits into MM:SS
  // RUN   | decrementing once per tick
  // PAUSE | value frozen until the next start (TIMER_PAUSE_EN only)
  // DONE  | alarm at 00:00, counting ticks back to IDLE
  typedef enum logic [2:0] {
    IDLE,
    ENTRY,
    RUN,
`ifdef TIMER_PAUSE_EN
    PAUSE,
`endif
    DONE
  } state_t;

  localparam logic [3:0] ALARM_LAST = 4'(ALARM_TICKS - 1);

  state_t     state;
  logic [3:0] min_t, min_o, sec_t, sec_o;
  logic [3:0] dec_min_t, dec_min_o, dec_sec_t, dec_sec_o;
  logic       dec_zero;
  logic [2:0] entry_cnt;
  logic [3:0] alarm_cnt;
  logic       running, done;
  logic       key_digit;

  // Only 1..9 count as digits; 5'h0F and anything else out of range is ignored.
  assign key_digit = i_key_valid && (i_bcd_data >= 5'd1) && (i_bcd_data <= 5'd9);

  always_comb begin
    dec_sec_o = sec_o - 4'd1;
    dec_sec_t = sec_t;
    dec_min_o = min_o;
    dec_min_t = min_t;
    if (sec_o == 4'd0) begin
      dec_sec_o = 4'd9;
      dec_sec_t = sec_t - 4'd1;
      if (sec_t == 4'd0) begin
        dec_sec_t = 4'd5;
        dec_min_o = min_o - 4'd1;
        if (min_o == 4'd0) begin
          dec_min_o = 4'd9;
          dec_min_t = min_t - 4'd1;
        end
      end
    end
    dec_zero = (dec_min_t == 4'd0) && (dec_min_o == 4'd0) &&
               (dec_sec_t == 4'd0) && (dec_sec_o == 4'd0);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      state     <= IDLE;
      min_t     <= 4'd0;
      min_o     <= 4'd0;
      sec_t     <= 4'd0;
      sec_o     <= 4'd0;
      entry_cnt <= 3'd0;
      alarm_cnt <= 4'd0;
      running   <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key_digit) begin
            sec_o     <= i_bcd_data[3:0];
            entry_cnt <= 3'd1;
            state     <= ENTRY;
          end
        end
        ENTRY: begin
          if (i_start) begin
            if (sec_t > 4'd5) begin
              sec_t <= 4'd5;
              sec_o <= 4'd9;
            end
            running <= 1'b1;
            state   <= RUN;
          end else if (key_digit) begin
            min_t <= min_o;
            min_o <= sec_t;
            sec_t <= sec_o;
            sec_o <= i_bcd_data[3:0];
            if (entry_cnt < 3'd4) entry_cnt <= entry_cnt + 3'd1;
          end
        end
        RUN: begin
`ifdef TIMER_PAUSE_EN
          if (i_start) begin
            running <= 1'b0;
            state   <= PAUSE;
          end else
`endif
          if (i_tick) begin
            min_t <= dec_min_t;
            min_o <= dec_min_o;
            sec_t <= dec_sec_t;
            sec_o <= dec_sec_o;
            if (dec_zero) begin
              running   <= 1'b0;
              done      <= 1'b1;
              alarm_cnt <= 4'd0;
              state     <= DONE;
            end
          end
        end
`ifdef TIMER_PAUSE_EN
        PAUSE: begin
          if (i_start) begin
            running <= 1'b1;
            state   <= RUN;
          end
        end
`endif
        DONE: begin
          if (i_tick) begin
            if (alarm_cnt == ALARM_LAST) begin
              alarm_cnt <= 4'd0;
              entry_cnt <= 3'd0;
              done      <= 1'b0;
              state     <= IDLE;
            end else begin
              alarm_cnt <= alarm_cnt + 4'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  assign o_min_t     = min_t;
  assign o_min_o     = min_o;
  assign o_sec_t     = sec_t;
  assign o_sec_o     = sec_o;
  assign o_entry_cnt = entry_cnt;
  assign o_running   = running;
  assign o_done      = done;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: expected outputs are queued as each step is driven and checked after the edge.
module tb_timer_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_key_valid = 1'b0;
  logic [4:0] i_bcd_data = 5'd0;
  logic       i_start = 1'b0;
  logic       i_clear = 1'b0;
  logic       i_tick = 1'b0;
  logic [3:0] o_min_t, o_min_o, o_sec_t, o_sec_o;
  logic [2:0] o_entry_cnt;
  logic       o_running, o_done;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string       tag;
    logic [20:0] val;
  } exp_t;
  exp_t sb[$];

  typedef enum {OP_NOP, OP_KEY, OP_START, OP_TICK, OP_CLEAR, OP_RST, OP_STTK} op_t;

  timer_ctrl #(.ALARM_TICKS(5)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_key_valid(i_key_valid), .i_bcd_data(i_bcd_data),
    .i_start(i_start), .i_clear(i_clear), .i_tick(i_tick),
    .o_min_t(o_min_t), .o_min_o(o_min_o), .o_sec_t(o_sec_t), .o_sec_o(o_sec_o),
    .o_entry_cnt(o_entry_cnt), .o_running(o_running), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic drive(input op_t op, input logic [4:0] d);
    i_key_valid = (op == OP_KEY);
    i_bcd_data  = (op == OP_KEY) ? d : 5'd0;
    i_start     = (op == OP_START) || (op == OP_STTK);
    i_tick      = (op == OP_TICK) || (op == OP_STTK);
    i_clear     = (op == OP_CLEAR);
    i_rst       = (op == OP_RST);
    @(posedge i_clk);
    #1;
    i_key_valid = 1'b0;
    i_bcd_data  = 5'd0;
    i_start     = 1'b0;
    i_tick      = 1'b0;
    i_clear     = 1'b0;
    i_rst       = 1'b0;
  endtask

  task automatic step(input string tag, input op_t op, input logic [4:0] d,
                      input logic [15:0] disp, input logic [2:0] cnt,
                      input logic run, input logic dn);
    exp_t e;
    logic [20:0] obs;
    e.tag = tag;
    e.val = {disp, cnt, run, dn};
    sb.push_back(e);
    drive(op, d);
    e = sb.pop_front();
    obs = {o_min_t, o_min_o, o_sec_t, o_sec_o, o_entry_cnt, o_running, o_done};
    vectors++;
    assert (obs === e.val) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (mmss,cnt,run,done)", e.tag, obs, e.val);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(OP_TICK, 5'd0);
  endtask

  initial begin
    drive(OP_RST, 5'd0);
    step("reset", OP_RST, 5'd0, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("idle_start_ignored", OP_START, 5'd0, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("key1", OP_KEY, 5'd1, 16'h0001, 3'd1, 1'b0, 1'b0);
    step("key2", OP_KEY, 5'd2, 16'h0012, 3'd2, 1'b0, 1'b0);
    step("key3", OP_KEY, 5'd3, 16'h0123, 3'd3, 1'b0, 1'b0);
    step("key4", OP_KEY, 5'd4, 16'h1234, 3'd4, 1'b0, 1'b0);
    step("key5_discard", OP_KEY, 5'd5, 16'h2345, 3'd4, 1'b0, 1'b0);
    step("key_nondigit", OP_KEY, 5'h0F, 16'h2345, 3'd4, 1'b0, 1'b0);

    step("clear_entry", OP_CLEAR, 5'd0, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("k165_a", OP_KEY, 5'd1, 16'h0001, 3'd1, 1'b0, 1'b0);
    step("k165_b", OP_KEY, 5'd6, 16'h0016, 3'd2, 1'b0, 1'b0);
    step("k165_c", OP_KEY, 5'd5, 16'h0165, 3'd3, 1'b0, 1'b0);
    step("start_force59", OP_START, 5'd0, 16'h0159, 3'd3, 1'b1, 1'b0);
    step("tick_0158", OP_TICK, 5'd0, 16'h0158, 3'd3, 1'b1, 1'b0);
    step("run_key_ignored", OP_KEY, 5'd3, 16'h0158, 3'd3, 1'b1, 1'b0);

    step("clear_run", OP_CLEAR, 5'd0, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("k21_a", OP_KEY, 5'd2, 16'h0002, 3'd1, 1'b0, 1'b0);
    step("k21_b", OP_KEY, 5'd1, 16'h0021, 3'd2, 1'b0, 1'b0);
    step("start_0021", OP_START, 5'd0, 16'h0021, 3'd2, 1'b1, 1'b0);
    step("tick1_0020", OP_TICK, 5'd0, 16'h0020, 3'd2, 1'b1, 1'b0);
    step("tick2_0019", OP_TICK, 5'd0, 16'h0019, 3'd2, 1'b1, 1'b0);
    ticks(17);
    step("tick20_0001", OP_TICK, 5'd0, 16'h0001, 3'd2, 1'b1, 1'b0);
    step("tick21_done", OP_TICK, 5'd0, 16'h0000, 3'd2, 1'b0, 1'b1);
    step("done_key_ignored", OP_KEY, 5'd4, 16'h0000, 3'd2, 1'b0, 1'b1);
    step("done_start_ignored", OP_START, 5'd0, 16'h0000, 3'd2, 1'b0, 1'b1);
    ticks(3);
    step("alarm_tick4", OP_TICK, 5'd0, 16'h0000, 3'd2, 1'b0, 1'b1);
    step("alarm_tick5_idle", OP_TICK, 5'd0, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("idle_again_key", OP_KEY, 5'd3, 16'h0003, 3'd1, 1'b0, 1'b0);

    step("clear_b", OP_CLEAR, 5'd0, 16'h0000, 3'd0, 1'b0, 1'b0);
    drive(OP_KEY, 5'd1);
    drive(OP_KEY, 5'd1);
    step("k111", OP_KEY, 5'd1, 16'h0111, 3'd3, 1'b0, 1'b0);
    drive(OP_START, 5'd0);
    ticks(10);
    step("tick_0100", OP_TICK, 5'd0, 16'h0100, 3'd3, 1'b1, 1'b0);
    step("min_borrow_0059", OP_TICK, 5'd0, 16'h0059, 3'd3, 1'b1, 1'b0);

    step("clear_c", OP_CLEAR, 5'd0, 16'h0000, 3'd0, 1'b0, 1'b0);
    drive(OP_KEY, 5'd1);
    drive(OP_KEY, 5'd1);
    drive(OP_KEY, 5'd1);
    step("k1111", OP_KEY, 5'd1, 16'h1111, 3'd4, 1'b0, 1'b0);
    drive(OP_START, 5'd0);
    ticks(70);
    step("tick_1000", OP_TICK, 5'd0, 16'h1000, 3'd4, 1'b1, 1'b0);
    step("mt_borrow_0959", OP_TICK, 5'd0, 16'h0959, 3'd4, 1'b1, 1'b0);
    step("clear_in_run", OP_CLEAR, 5'd0, 16'h0000, 3'd0, 1'b0, 1'b0);

    drive(OP_KEY, 5'd1);
    step("k16", OP_KEY, 5'd6, 16'h0016, 3'd2, 1'b0, 1'b0);
    step("start_0016", OP_START, 5'd0, 16'h0016, 3'd2, 1'b1, 1'b0);
    ticks(5);
    step("tick_0010", OP_TICK, 5'd0, 16'h0010, 3'd2, 1'b1, 1'b0);
`ifdef TIMER_PAUSE_EN
    step("start_tick_pause", OP_STTK, 5'd0, 16'h0010, 3'd2, 1'b0, 1'b0);
    step("pause_tick_ignored", OP_TICK, 5'd0, 16'h0010, 3'd2, 1'b0, 1'b0);
    step("pause_key_ignored", OP_KEY, 5'd2, 16'h0010, 3'd2, 1'b0, 1'b0);
    step("resume", OP_START, 5'd0, 16'h0010, 3'd2, 1'b1, 1'b0);
    step("resume_tick_0009", OP_TICK, 5'd0, 16'h0009, 3'd2, 1'b1, 1'b0);
    step("pause_again", OP_START, 5'd0, 16'h0009, 3'd2, 1'b0, 1'b0);
    step("clear_in_pause", OP_CLEAR, 5'd0, 16'h0000, 3'd0, 1'b0, 1'b0);
`else
    step("start_tick_applied", OP_STTK, 5'd0, 16'h0009, 3'd2, 1'b1, 1'b0);
    step("start_ignored", OP_START, 5'd0, 16'h0009, 3'd2, 1'b1, 1'b0);
    step("tick_0008", OP_TICK, 5'd0, 16'h0008, 3'd2, 1'b1, 1'b0);
    step("clear_d", OP_CLEAR, 5'd0, 16'h0000, 3'd0, 1'b0, 1'b0);
`endif

    step("k2", OP_KEY, 5'd2, 16'h0002, 3'd1, 1'b0, 1'b0);
    drive(OP_START, 5'd0);
    drive(OP_TICK, 5'd0);
    step("done_0002", OP_TICK, 5'd0, 16'h0000, 3'd1, 1'b0, 1'b1);
    drive(OP_TICK, 5'd0);
    step("clear_in_done", OP_CLEAR, 5'd0, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("clear_in_done_tick", OP_TICK, 5'd0, 16'h0000, 3'd0, 1'b0, 1'b0);

    drive(OP_KEY, 5'd3);
    step("k33", OP_KEY, 5'd3, 16'h0033, 3'd2, 1'b0, 1'b0);
    drive(OP_START, 5'd0);
    step("tick_0032", OP_TICK, 5'd0, 16'h0032, 3'd2, 1'b1, 1'b0);
    step("rst_mid_run", OP_RST, 5'd0, 16'h0000, 3'd0, 1'b0, 1'b0);
    step("post_rst_tick", OP_TICK, 5'd0, 16'h0000, 3'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
